bus_coherence_ctrl: RTL
=======================

BUS_COHERENCE_CTRL -- requirements
Module: bus_coherence_ctrl

Interface
REQ-001 SHALL have: CLK  in  1  clock, rising edge; nRST  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: dREN  in  2  per-cache block-fill word read request, bit i = cache i.
REQ-003 SHALL have: dWEN  in  2  per-cache word write request (eviction or snoop writeback).
REQ-004 SHALL have: daddr0, daddr1  in  32  per-cache word address; dstore0, dstore1  in  32  per-cache write data.
REQ-005 SHALL have: ccwrite  in  2  requester read-for-write intent, sampled with dREN; ccdirty  in  2  snooped cache holds ccsnoopaddr block dirty.
REQ-006 SHALL have: dwait  out  2  1 = word not complete; dload0, dload1  out  32  read data to cache i.
REQ-007 SHALL have: ccwait  out  2  snoop hold to cache i; ccinv  out  2  invalidate snooped block in cache i; ccsnoopaddr  out  32  snoop address.
REQ-008 SHALL have: ramREN, ramWEN  out  1; ramaddr, ramstore  out  32; ramload  in  32; ramready  in  1  RAM word access complete this cycle.

Function
REQ-009 States SHALL be IDLE, WB1, WB2, SNOOP, SHARE1, SHARE2, RAM1, RAM2; g = granted cache, o = other cache (~g).
REQ-010 Request of cache i SHALL be dREN[i] | dWEN[i]; dWEN[i] wins over dREN[i] in the same cache.
REQ-011 IDLE: single requester granted; both requesting -> grant ~lastgrant (round-robin); grant registered on IDLE exit.
REQ-012 IDLE -> WB1 if granted dWEN, else SNOOP; no request -> stay IDLE.
REQ-013 WB1/WB2: ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g], dwait[g]=~ramready; advance on ramready; WB2 -> IDLE.
REQ-014 SNOOP: exactly one cycle; ccsnoopaddr=daddr[g]; next = ccdirty[o] ? SHARE1 : RAM1.
REQ-015 ccwait[o]=1 and ccinv[o]=ccwrite[g] SHALL hold from SNOOP through SHARE2/RAM2 inclusive; ccsnoopaddr held at daddr[g] throughout.
REQ-016 SHARE1/SHARE2 (cache-to-cache): while dWEN[o]=1, ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o], dload[g]=dstore[o], dwait[g]=dwait[o]=~ramready; dWEN[o]=0 -> ramWEN=0, hold state.
REQ-017 SHARE1 -> SHARE2 -> IDLE, each on ramready with dWEN[o]=1.
REQ-018 RAM1/RAM2: ramREN=1, ramaddr=daddr[g], dload[g]=ramload, dwait[g]=~ramready; RAM1 -> RAM2 -> IDLE on ramready.
REQ-019 lastgrant <= g on every return to IDLE; ramREN and ramWEN never both 1.
REQ-020 Non-granted cache: dwait=1, dload=0; ccwait[g] and ccinv[g] never asserted.
REQ-021 Granted request withdrawn (dREN[g]|dWEN[g]=0) in WB*/RAM*/SHARE* -> RAM strobes 0 that cycle, IDLE next cycle.
REQ-022 ramready held 0: state and all outputs hold indefinitely; no timeout.
REQ-023 ccdirty[o] sampled only in SNOOP; ignored in all other states.
REQ-024 Cache addresses consecutive words; controller passes daddr through unmodified, no increment.

Reset
REQ-025 nRST=0 SHALL force IDLE, lastgrant=1 (cache 0 wins first tie), dwait=2'b11, all other outputs 0, asynchronously, including mid-transaction.
REQ-026 First rising CLK after nRST release SHALL evaluate IDLE arbitration normally.

Verification
REQ-027 Both caches assert dREN after reset, ccdirty=0 -> cache 0 granted, SNOOP, RAM1, RAM2, IDLE; then cache 1 served; ccwait[1]=1 during cache 0 service.
REQ-028 Cache 1 dWEN, daddr1=0x100, dstore1=0xDEADBEEF, ramready=1 -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF, dwait[1]=0; two words then IDLE.
REQ-029 Cache 0 dREN+ccwrite[0]=1 at 0x200, ccdirty[1]=1, cache 1 dWEN with 0xCAFE0001 -> dload0=0xCAFE0001, ramWEN=1 ramaddr=0x200, ccinv[1]=1 until IDLE.
REQ-030 ramready=0 for 10 cycles in RAM1 -> dwait[g]=1, state held; ramready=1 -> dload[g]=ramload, RAM2 next.
REQ-031 nRST asserted in SHARE2 -> immediate IDLE, ccwait=0, ccinv=0, dwait=2'b11, ram strobes 0.

Source files
------------

// File: rtl/bus_coherence_ctrl.sv
// Two-cache snooping bus controller: arbitrates block fills and writebacks onto one word-wide RAM port.
// Latency: grant is decided in IDLE and registered on exit; RAM words complete combinationally on ramready.
// Backpressure: ramready low stalls the current word indefinitely; dwait stays high until the word lands.
//
// Ports:
//   CLK, nRST                  clock (rising edge), asynchronous active-low reset
//   dREN, dWEN                 per-cache read / write word requests (bit i = cache i)
//   daddr0/1, dstore0/1        per-cache word address and write data
//   ccwrite, ccdirty           requester write intent, snooped-cache dirty flag
//   dwait, dload0/1            per-cache word-not-done and read data
//   ccwait, ccinv, ccsnoopaddr snoop hold, invalidate and address to the other cache
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramready   single RAM word port
module bus_coherence_ctrl (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [1:0]  dREN,
   input  logic [1:0]  dWEN,
   input  logic [31:0] daddr0,
   input  logic [31:0] daddr1,
   input  logic [31:0] dstore0,
   input  logic [31:0] dstore1,
   input  logic [1:0]  ccwrite,
   input  logic [1:0]  ccdirty,
   output logic [1:0]  dwait,
   output logic [31:0] dload0,
   output logic [31:0] dload1,
   output logic [1:0]  ccwait,
   output logic [1:0]  ccinv,
   output logic [31:0] ccsnoopaddr,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramready
);

   typedef enum logic [2:0] {
      IDLE, WB1, WB2, SNOOP, SHARE1, SHARE2, RAM1, RAM2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_grant;
   logic        r_lastgrant;

   logic [1:0]  w_req;
   logic        w_arb;
   logic        w_o;
   logic        w_greq;
   logic [31:0] w_addr_g;
   logic [31:0] w_addr_o;
   logic [31:0] w_store_g;
   logic [31:0] w_store_o;
   logic [31:0] w_load_g;
   logic        w_dwait_g;
   logic        w_dwait_o;
   logic        w_cc_hold;

   assign w_req     = dREN | dWEN;
   assign w_o       = ~r_grant;
   assign w_greq    = w_req[r_grant];
   assign w_addr_g  = r_grant ? daddr1  : daddr0;
   assign w_addr_o  = r_grant ? daddr0  : daddr1;
   assign w_store_g = r_grant ? dstore1 : dstore0;
   assign w_store_o = r_grant ? dstore0 : dstore1;

   // Round-robin only matters on a tie; a lone requester always wins.
   always_comb begin
      w_arb = r_lastgrant;
      case (w_req)
         2'b01:   w_arb = 1'b0;
         2'b10:   w_arb = 1'b1;
         2'b11:   w_arb = ~r_lastgrant;
         default: w_arb = r_lastgrant;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= IDLE;
         r_grant     <= 1'b0;
         r_lastgrant <= 1'b1;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_next != IDLE)
            r_grant <= w_arb;
         if (r_state != IDLE && w_next == IDLE)
            r_lastgrant <= r_grant;
      end
   end

   always_comb begin
      w_next    = r_state;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = 32'h0;
      ramstore  = 32'h0;
      w_load_g  = 32'h0;
      w_dwait_g = 1'b1;
      w_dwait_o = 1'b1;
      w_cc_hold = 1'b0;
      case (r_state)
         IDLE: begin
            // Within one cache a write request beats a read request.
            if (|w_req)
               w_next = dWEN[w_arb] ? WB1 : SNOOP;
         end
         WB1, WB2: begin
            if (!w_greq) begin
               w_next = IDLE;
            end else begin
               ramWEN    = 1'b1;
               ramaddr   = w_addr_g;
               ramstore  = w_store_g;
               w_dwait_g = ~ramready;
               if (ramready)
                  w_next = (r_state == WB1) ? WB2 : IDLE;
            end
         end
         SNOOP: begin
            // The only state in which the other cache's dirty flag is looked at.
            w_cc_hold = 1'b1;
            w_next    = ccdirty[w_o] ? SHARE1 : RAM1;
         end
         SHARE1, SHARE2: begin
            w_cc_hold = 1'b1;
            if (!w_greq) begin
               w_next = IDLE;
            end else if (dWEN[w_o]) begin
               // Dirty owner's writeback goes to RAM and straight into the requester.
               ramWEN    = 1'b1;
               ramaddr   = w_addr_o;
               ramstore  = w_store_o;
               w_load_g  = w_store_o;
               w_dwait_g = ~ramready;
               w_dwait_o = ~ramready;
               if (ramready)
                  w_next = (r_state == SHARE1) ? SHARE2 : IDLE;
            end
         end
         RAM1, RAM2: begin
            w_cc_hold = 1'b1;
            if (!w_greq) begin
               w_next = IDLE;
            end else begin
               ramREN    = 1'b1;
               ramaddr   = w_addr_g;
               w_load_g  = ramload;
               w_dwait_g = ~ramready;
               if (ramready)
                  w_next = (r_state == RAM1) ? RAM2 : IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Steer granted/other views back onto the per-cache output bits.
   assign dwait       = r_grant ? {w_dwait_g, w_dwait_o} : {w_dwait_o, w_dwait_g};
   assign dload0      = r_grant ? 32'h0 : w_load_g;
   assign dload1      = r_grant ? w_load_g : 32'h0;
   assign ccwait      = w_cc_hold ? (r_grant ? 2'b01 : 2'b10) : 2'b00;
   assign ccinv       = w_cc_hold ? (r_grant ? {1'b0, ccwrite[1]} : {ccwrite[0], 1'b0}) : 2'b00;
   assign ccsnoopaddr = w_cc_hold ? w_addr_g : 32'h0;

endmodule
